// File: rtl/link_sequencer_if.sv
// link_sequencer_if: handshake/status bundle between the link sequencer and its datapath stages
interface link_sequencer_if #(
    parameter int CNT_W = 10
);
    logic             start;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             rx_finish;
    logic [3:0]       rx_error;
    logic [7:0]       rx_crc;
    logic [7:0]       crc_ref;
    logic             tx_finish;
    logic             rx_enable;
    logic             drain_enable;
    logic             com_enable;
    logic             fifo_reset;
    logic [2:0]       state;
    logic [7:0]       frame_count;
    logic [7:0]       err_count;

    modport master (
        output start, fifo_count, fifo_empty, rx_finish, rx_error, rx_crc, crc_ref, tx_finish,
        input  rx_enable, drain_enable, com_enable, fifo_reset, state, frame_count, err_count
    );

    modport slave (
        input  start, fifo_count, fifo_empty, rx_finish, rx_error, rx_crc, crc_ref, tx_finish,
        output rx_enable, drain_enable, com_enable, fifo_reset, state, frame_count, err_count
    );
endinterface

// File: rtl/link_sequencer.sv
// link_sequencer: sequences receive -> check -> drain/flush with FIFO backpressure, drain watchdog and stats; define SEQ_CRC_CHECK_EN to also flush on CRC mismatch
module link_sequencer #(
    parameter int CNT_W        = 10,
    parameter int HI_WATER     = 1000,
    parameter int LO_WATER     = 512,
    parameter int FLUSH_CYCLES = 4,
    parameter int TIMEOUT      = 4095
) (
    input logic             clk,
    input logic             reset,
    link_sequencer_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RECEIVE = 3'd1,
        HOLD    = 3'd2,
        CHECK   = 3'd3,
        DRAIN   = 3'd4,
        FLUSH   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            bad_q, bad_d;
    logic            empty_seen_q, empty_seen_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [7:0]      frame_count_q, frame_count_d;
    logic [7:0]      err_count_q, err_count_d;
    logic            rx_enable_q, rx_enable_d;
    logic            drain_enable_q, drain_enable_d;
    logic            com_enable_q, com_enable_d;
    logic            fifo_reset_q, fifo_reset_d;
    logic            frame_bad;

`ifdef SEQ_CRC_CHECK_EN
    assign frame_bad = (bus.rx_error != 4'd0) || (bus.rx_crc != bus.crc_ref);
`else
    logic unused_crc;
    assign unused_crc = ^{bus.rx_crc, bus.crc_ref};
    assign frame_bad  = (bus.rx_error != 4'd0);
`endif

    // state register plus every counter and registered output
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            bad_q          <= 1'b0;
            empty_seen_q   <= 1'b0;
            wd_q           <= '0;
            flush_cnt_q    <= '0;
            frame_count_q  <= 8'd0;
            err_count_q    <= 8'd0;
            rx_enable_q    <= 1'b0;
            drain_enable_q <= 1'b0;
            com_enable_q   <= 1'b0;
            fifo_reset_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            bad_q          <= bad_d;
            empty_seen_q   <= empty_seen_d;
            wd_q           <= wd_d;
            flush_cnt_q    <= flush_cnt_d;
            frame_count_q  <= frame_count_d;
            err_count_q    <= err_count_d;
            rx_enable_q    <= rx_enable_d;
            drain_enable_q <= drain_enable_d;
            com_enable_q   <= com_enable_d;
            fifo_reset_q   <= fifo_reset_d;
        end
    end

    // next-state: rx_finish beats high-water, empty-exit beats watchdog
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RECEIVE;
            RECEIVE: if (bus.rx_finish) state_d = CHECK;
                     else if (bus.fifo_count >= CNT_W'(HI_WATER)) state_d = HOLD;
            HOLD:    if (bus.fifo_count <= CNT_W'(LO_WATER)) state_d = RECEIVE;
            CHECK:   state_d = bad_q ? FLUSH : DRAIN;
            DRAIN:   if (empty_seen_q && bus.fifo_empty) state_d = RECEIVE;
                     else if (!bus.tx_finish && wd_q == WD_W'(TIMEOUT - 1)) state_d = FLUSH;
            FLUSH:   if (flush_cnt_q == FC_W'(FLUSH_CYCLES - 1)) state_d = RECEIVE;
            default: state_d = IDLE;
        endcase
    end

    // counters and frame verdict, latched when the receive stage reports completion
    always_comb begin
        bad_d         = (state_q == RECEIVE && bus.rx_finish) ? frame_bad : bad_q;
        empty_seen_d  = (state_q == DRAIN) && (state_d == DRAIN) && bus.fifo_empty;
        wd_d          = (state_q == DRAIN && state_d == DRAIN && !bus.tx_finish) ? wd_q + WD_W'(1) : '0;
        flush_cnt_d   = (state_q == FLUSH && state_d == FLUSH) ? flush_cnt_q + FC_W'(1) : '0;
        frame_count_d = (state_q == DRAIN && state_d == RECEIVE) ? frame_count_q + 8'd1 : frame_count_q;
        err_count_d   = (state_q != FLUSH && state_d == FLUSH && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end

    // outputs decoded from the upcoming state so they register alongside it
    always_comb begin
        rx_enable_d    = (state_d == RECEIVE);
        drain_enable_d = (state_d == HOLD) || (state_d == DRAIN);
        com_enable_d   = (state_d == HOLD) || (state_d == DRAIN);
        fifo_reset_d   = (state_d == FLUSH);
    end

    assign bus.state        = state_q;
    assign bus.rx_enable    = rx_enable_q;
    assign bus.drain_enable = drain_enable_q;
    assign bus.com_enable   = com_enable_q;
    assign bus.fifo_reset   = fifo_reset_q;
    assign bus.frame_count  = frame_count_q;
    assign bus.err_count    = err_count_q;
endmodule
